// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues a 0x03 READ with a 24-bit address, then streams
// 32-bit little-endian words out over a valid/ready response port. SPI mode 0,
// SCK derived from wb_clk_i by CLK_DIV, CSB kept high for CSB_IDLE cycles
// between transactions.
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_IDLE = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);
    typedef enum logic [2:0] {IDLE, CMD, DATA, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CSB_IDLE - 1);
    localparam logic [7:0] READ_CMD = 8'h03;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [31:0] cmd_word;
    logic [7:0]  len;
    logic [8:0]  word_cnt;   // 9 bits so len=255 (256 words) never wraps
    logic [7:0]  gap_cnt;
    logic        tick, sck_rise, sck_fall, bits_done, hs;

    assign cmd_word  = {READ_CMD, req_addr};
    assign req_ready = (state == IDLE) && !wb_rst_i;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and SCK edge strobes.
    always_comb begin
        state_nxt = state;
        tick      = (div_cnt == DIV_LAST);
        // SCK only rises while shifting; it may still fall in HOLD so the
        // last data bit keeps its full high phase.
        sck_rise  = tick && !flash_clk && (state == CMD || state == DATA);
        sck_fall  = tick && flash_clk && (state == CMD || state == DATA || state == HOLD);
        bits_done = (bit_cnt == 6'd32);
        hs        = (state == HOLD) && rsp_valid && rsp_ready;
        case (state)
            IDLE:    if (req_valid) state_nxt = CMD;
            CMD:     if (sck_fall && bits_done) state_nxt = DATA;
            DATA:    if (bits_done) state_nxt = HOLD;
            HOLD:    if (hs) state_nxt = rsp_last ? GAP : DATA;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: SCK divider, command shifter, data assembly, response and gap.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            len       <= '0;
            word_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            if (sck_rise || sck_fall) flash_clk <= ~flash_clk;
            if (state == CMD || state == DATA || (state == HOLD && flash_clk))
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            case (state)
                IDLE: if (req_valid) begin
                    flash_csb <= 1'b0;
                    flash_io0 <= cmd_word[31];
                    tx_sr     <= {cmd_word[30:0], 1'b0};
                    len       <= req_len;
                    word_cnt  <= '0;
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                end
                CMD: begin
                    if (sck_rise) bit_cnt <= bit_cnt + 6'd1;
                    // MOSI moves only on falling SCK, after the flash sampled it.
                    if (sck_fall) begin
                        if (bits_done) begin
                            flash_io0 <= 1'b0;
                            bit_cnt   <= '0;
                        end else begin
                            flash_io0 <= tx_sr[31];
                            tx_sr     <= {tx_sr[30:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        rx_sr   <= {rx_sr[30:0], flash_io1};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                    // Bytes arrive MSB first; first byte on the wire is the low byte.
                    if (bits_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                        rsp_last  <= (word_cnt == {1'b0, len});
                        bit_cnt   <= '0;
                    end
                end
                HOLD: if (hs) begin
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                    word_cnt  <= word_cnt + 9'd1;
                    if (rsp_last) begin
                        flash_csb <= 1'b1;
                        flash_clk <= 1'b0;
                        gap_cnt   <= '0;
                    end else if (!flash_clk) begin
                        // SCK already parked low: restart so the next rise
                        // lands a full half-period after the handshake.
                        div_cnt <= '0;
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1), each
// with a small behavioural SPI flash whose byte at address a is a[7:0].
module tb_spi_flash_reader;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid;
    logic [23:0] req_addr;
    logic [7:0] req_len;
    logic rsp_ready;
    logic [1:0] req_ready, rsp_valid, rsp_last, busy, csb, sck, io0;
    logic [1:0] io1;
    logic [1:0][31:0] rsp_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] m_cmd [2] = '{32'h0, 32'h0};
    int m_in [2] = '{0, 0};
    int m_out [2] = '{0, 0};
    int m_rises [2] = '{0, 0};
    int m_csb_rises [2] = '{0, 0};
    logic m_sck_q [2] = '{1'b0, 1'b0};
    logic m_csb_q [2] = '{1'b1, 1'b1};

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(2), .CSB_IDLE(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]), .busy(busy[0]),
        .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_io0(io0[0]), .flash_io1(io1[0])
    );

    spi_flash_reader #(.CLK_DIV(1), .CSB_IDLE(4)) dut_div1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]), .busy(busy[1]),
        .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_io0(io0[1]), .flash_io1(io1[1])
    );

    function automatic logic flash_bit(input logic [31:0] cmd, input int n);
        logic [7:0] b;
        b = cmd[7:0] + 8'(n / 8);
        return b[7 - (n % 8)];
    endfunction

    // Flash model: captures 32 command bits on SCK rise, drives data on SCK fall.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_sck_q[i] <= sck[i];
            m_csb_q[i] <= csb[i];
            if (csb[i] && !m_csb_q[i]) m_csb_rises[i] <= m_csb_rises[i] + 1;
            if (csb[i]) begin
                m_in[i]  <= 0;
                m_out[i] <= 0;
                io1[i]   <= 1'b0;
            end else if (sck[i] && !m_sck_q[i]) begin
                m_rises[i] <= m_rises[i] + 1;
                if (m_in[i] < 32) begin
                    m_cmd[i] <= {m_cmd[i][30:0], io0[i]};
                    m_in[i]  <= m_in[i] + 1;
                end
            end else if (!sck[i] && m_sck_q[i] && m_in[i] == 32) begin
                io1[i]   <= flash_bit(m_cmd[i], m_out[i]);
                m_out[i] <= m_out[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic [23:0] a, input logic [7:0] l);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 500) begin @(negedge clk); n++; end
        chk("req_ready before issue", 32'(req_ready[i]), 32'd1);
        req_addr = a;
        req_len = l;
        req_valid[i] = 1'b1;
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic get_word(input int i, input int stall, output logic [31:0] data, output logic last);
        int n = 0;
        bit stable = 1'b1;
        rsp_ready = (stall == 0);
        while (!rsp_valid[i] && n < 3000) begin @(negedge clk); n++; end
        chk("rsp_valid within bound", 32'(rsp_valid[i]), 32'd1);
        data = rsp_data[i];
        last = rsp_last[i];
        if (stall > 0) begin
            @(negedge clk);
            for (int k = 0; k < stall; k++) begin
                if (sck[i] !== 1'b0 || rsp_valid[i] !== 1'b1 ||
                    rsp_data[i] !== data || rsp_last[i] !== last) stable = 1'b0;
                @(negedge clk);
            end
            chk("stall sck low and rsp stable", 32'(stable), 32'd1);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = (stall == 0);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] && n < 3000) begin @(negedge clk); n++; end
        chk("busy clears", 32'(busy[i]), 32'd0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        int          stall;
        logic [31:0] w0, w1, w2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] d, expw;
        logic [31:0] exp_w [3];
        logic [7:0] b0;
        logic l;
        bit quiet;
        int r0, c0, n, t0, t1;

        vecs[0] = '{24'h000000, 8'd0, 0, 32'h03020100, 32'h0, 32'h0};
        vecs[1] = '{24'h000004, 8'd2, 0, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        vecs[2] = '{24'h000004, 8'd2, 20, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        vecs[3] = '{24'h000008, 8'd1, 3, 32'h0B0A0908, 32'h0F0E0D0C, 32'h0};

        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_len = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset csb", 32'(csb[0]), 32'd1);
        chk("reset sck", 32'(sck[0]), 32'd0);
        chk("reset io0", 32'(io0[0]), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rsp_last", 32'(rsp_last[0]), 32'd0);
        chk("reset rsp_data", rsp_data[0], 32'd0);
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset req_ready", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("req_ready after release", 32'(req_ready[0]), 32'd1);

        // Table-driven requests on the CLK_DIV=2 instance.
        foreach (vecs[v]) begin
            exp_w = '{vecs[v].w0, vecs[v].w1, vecs[v].w2};
            r0 = m_rises[0];
            c0 = m_csb_rises[0];
            issue(0, vecs[v].addr, vecs[v].len);
            for (int k = 0; k <= int'(vecs[v].len); k++) begin
                get_word(0, vecs[v].stall, d, l);
                chk($sformatf("vec%0d word%0d data", v, k), d, exp_w[k]);
                chk($sformatf("vec%0d word%0d last", v, k), 32'(l), 32'(k == int'(vecs[v].len)));
            end
            wait_idle(0);
            chk($sformatf("vec%0d cmd bits", v), m_cmd[0], {8'h03, vecs[v].addr});
            chk($sformatf("vec%0d sck rises", v), 32'(m_rises[0] - r0), 32'(32 * (int'(vecs[v].len) + 2)));
            chk($sformatf("vec%0d csb windows", v), 32'(m_csb_rises[0] - c0), 32'd1);
        end

        // Reset in the middle of the data phase.
        issue(0, 24'h000000, 8'd0);
        n = 0;
        while (!(m_in[0] == 32 && m_out[0] == 10) && n < 1000) begin @(negedge clk); n++; end
        chk("reached data bit 10", 32'(n < 1000), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset csb", 32'(csb[0]), 32'd1);
        chk("async reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("req_ready after mid reset", 32'(req_ready[0]), 32'd1);
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) quiet = 1'b0;
        end
        chk("no rsp after mid reset", 32'(quiet), 32'd1);
        issue(0, 24'h000008, 8'd0);
        get_word(0, 0, d, l);
        chk("post-reset word", d, 32'h0B0A0908);
        chk("post-reset last", 32'(l), 32'd1);
        wait_idle(0);

        // req_valid held through a transaction: only one served, next after gap.
        c0 = m_csb_rises[0];
        @(negedge clk);
        req_addr = 24'h000000;
        req_len = 8'd0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_addr = 24'h000004;
        get_word(0, 0, d, l);
        chk("held req first word", d, 32'h03020100);
        chk("held req first last", 32'(l), 32'd1);
        n = 0;
        while (!csb[0] && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (csb[0] && n < 200) begin @(negedge clk); n++; end
        chk("csb gap length ok", 32'(n >= 4 && n < 200), 32'd1);
        req_valid[0] = 1'b0;
        get_word(0, 0, d, l);
        chk("held req second word", d, 32'h07060504);
        wait_idle(0);
        chk("held req csb windows", 32'(m_csb_rises[0] - c0), 32'd2);

        // CLK_DIV=1 instance: SCK period and basic read.
        r0 = m_rises[1];
        issue(1, 24'h000000, 8'd0);
        n = 0;
        while (!sck[1] && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        while (sck[1] && n < 100) begin @(negedge clk); n++; end
        while (!sck[1] && n < 150) begin @(negedge clk); n++; end
        t1 = cyc;
        chk("div1 sck period", 32'(t1 - t0), 32'd2);
        get_word(1, 0, d, l);
        chk("div1 word", d, 32'h03020100);
        chk("div1 last", 32'(l), 32'd1);
        wait_idle(1);
        chk("div1 sck rises", 32'(m_rises[1] - r0), 32'd64);
        chk("div1 cmd bits", m_cmd[1], 32'h03000000);

        // Maximum length: 256 words, last flagged only on the final one.
        issue(1, 24'h000010, 8'd255);
        for (int k = 0; k < 256; k++) begin
            b0 = 8'h10 + 8'(4 * k);
            expw = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            get_word(1, 0, d, l);
            chk($sformatf("len255 word%0d data", k), d, expw);
            chk($sformatf("len255 word%0d last", k), 32'(l), 32'(k == 255));
        end
        wait_idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 2, setting the SCK half-period in wb_clk_i cycles (legal 1..255).
REQ-002 The block SHALL have a parameter CSB_IDLE, default 4, setting the minimum wb_clk_i cycles flash_csb stays high between transactions.
REQ-003 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_addr  input  24  flash byte address of the first byte.
REQ-008 req_len  input  8  number of 32-bit words to read, minus one.
REQ-009 rsp_valid  output  1  rsp_data holds a completed word.
REQ-010 rsp_ready  input  1  consumer accepts the word.
REQ-011 rsp_data  output  32  assembled word.
REQ-012 rsp_last  output  1  current word is the final word of the request.
REQ-013 busy  output  1  transaction in progress, including the CSB_IDLE gap.
REQ-014 flash_csb  output  1  flash chip select, active-low.
REQ-015 flash_clk  output  1  SCK, SPI mode 0.
REQ-016 flash_io0  output  1  MOSI.
REQ-017 flash_io1  input  1  MISO.

Function
REQ-018 States SHALL be IDLE, CMD, DATA, HOLD, GAP; req_ready SHALL be 1 only in IDLE.
REQ-019 On req_valid && req_ready, the block SHALL latch addr and len, enter CMD, and next cycle drive flash_csb=0, flash_clk=0, flash_io0=bit 7 of 0x03.
REQ-020 SCK SHALL toggle every CLK_DIV cycles while in CMD or DATA; SCK period = 2*CLK_DIV cycles.
REQ-021 In CMD the block SHALL shift out 32 bits MSB first: 0x03 then req_addr[23:16], [15:8], [7:0]; flash_io0 SHALL change only on SCK falling edges (or CSB assertion for bit 0).
REQ-022 After the 32nd CMD rising edge and the following falling edge, the block SHALL enter DATA; flash_io0 SHALL be 0 in DATA, HOLD, GAP, IDLE.
REQ-023 In DATA the block SHALL sample flash_io1 on each SCK rising edge, bytes MSB first; the first received byte SHALL land in rsp_data[7:0], second in [15:8], third in [23:16], fourth in [31:24].
REQ-024 One cycle after the 32nd data rising edge the block SHALL assert rsp_valid with the word and enter HOLD; SCK SHALL fall CLK_DIV cycles after that rising edge, then remain low in HOLD.
REQ-025 rsp_valid and rsp_data SHALL be stable until rsp_valid && rsp_ready; rsp_last SHALL be 1 when the word count equals req_len+1.
REQ-026 On the HOLD handshake with words remaining, the block SHALL return to DATA with flash_csb held low, next rising SCK edge CLK_DIV cycles after the handshake (flash streaming continues, no re-addressing).
REQ-027 On the HOLD handshake of the last word, the block SHALL drive flash_csb=1 the next cycle and enter GAP for CSB_IDLE cycles, then IDLE.
REQ-028 Handshake in the same cycle rsp_valid rises SHALL be accepted (no minimum hold).
REQ-029 req_valid while busy SHALL be ignored; no queuing.
REQ-030 req_len=255 SHALL read 256 words; internal word counter SHALL be 9 bits or compare against len without wrap.
REQ-031 Address wrap past 0xFFFFFF is the flash's responsibility; the block SHALL NOT track addresses after CMD.

Reset
REQ-032 While wb_rst_i=1: flash_csb=1, flash_clk=0, flash_io0=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, req_ready=0, state IDLE.
REQ-033 Reset asserted mid-transaction SHALL deassert flash_csb immediately (asynchronously) and discard any partial word; req_ready SHALL be 1 the first cycle after release.

Verification
REQ-034 CLK_DIV=2, spiflash model with bytes 0x00..0x0F at 0x000000; request addr=0x000000, len=0, rsp_ready=1 -> flash_io0 carries 0x03000000, rsp_data=0x03020100, rsp_last=1, 64 SCK rising edges total.
REQ-035 Request addr=0x000004, len=2, rsp_ready=1 -> words 0x07060504, 0x0B0A0908, 0x0F0E0D0C; single CSB low window; rsp_last only on third.
REQ-036 Same as REQ-035 with rsp_ready=0 for 20 cycles per word -> identical data; flash_clk low and rsp_data stable throughout each stall.
REQ-037 Reset pulsed during 10th data bit -> flash_csb=1 within same cycle, rsp_valid never asserted; new request addr=0x000008, len=0 afterward -> 0x0B0A0908.
REQ-038 req_valid held during transaction -> only first request served; after GAP (flash_csb high >= CSB_IDLE cycles) second accepted.
REQ-039 CLK_DIV=1 -> SCK period 2 cycles, REQ-034 data unchanged.
